// File: rtl/protected_rf_pkg.sv
// Shared definitions for the protected register file: fault codes reported
// on the fault_code output.
package protected_rf_pkg;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FC_NONE         = 2'd0;
    localparam fault_code_t FC_READ_DENIED  = 2'd1;
    localparam fault_code_t FC_WRITE_DENIED = 2'd2;
    localparam fault_code_t FC_ILLEGAL      = 2'd3;

endpackage

// File: rtl/protected_rf_entry.sv
// One protected storage entry: data word, owner ID and owned flag.
// The top level only asserts an operation strobe when the operation is legal
// and addresses this entry. The entry itself applies the ownership rules, so
// a strobe from a non-owner leaves the state unchanged.
module protected_rf_entry #(
    parameter int WIDTH = 8,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ID_W-1:0]  req_id_i,
    input  logic             claim_i,
    input  logic             release_i,
    input  logic             write_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             can_access_o,
    output logic             is_owned_o
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic             owned_q, owned_d;

    assign data_o       = data_q;
    assign is_owned_o   = owned_q;
    assign can_access_o = owned_q && (owner_q == req_id_i);

    // Next-state: claim takes a free entry, release scrubs it, write updates data.
    always_comb begin
        data_d  = data_q;
        owner_d = owner_q;
        owned_d = owned_q;
        if (claim_i && !owned_q) begin
            owned_d = 1'b1;
            owner_d = req_id_i;
        end else if (release_i && can_access_o) begin
            owned_d = 1'b0;
            owner_d = '0;
            data_d  = '0;
        end else if (write_i && can_access_o) begin
            data_d = wr_data_i;
        end
    end

    // Entry state register; reset clears data as well as ownership.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            owner_q <= '0;
            owned_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            owner_q <= owner_d;
            owned_q <= owned_d;
        end
    end

endmodule

// File: rtl/protected_register_file.sv
// DEPTH x WIDTH register file with per-entry ownership. Requests are
// checked against the ownership state from before the clock edge. Denied
// or malformed requests raise a one-cycle fault with a prioritised code.
// Optional build macro RD_HIZ_EN: when it is defined, rd_data floats to
// all-Z in every cycle where rd_valid is low, for shared-bus use.
module protected_register_file
    import protected_rf_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  DEPTH  = 8,
    parameter int  ID_W   = 4,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   req_id,
    input  logic              wr_en,
    input  logic              claim,
    input  logic              release_i,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              fault,
    output fault_code_t       fault_code
);

    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_access;
    logic [DEPTH-1:0] ent_owned;
    logic [DEPTH-1:0] wr_sel;

    logic             wr_addr_ok, rd_addr_ok;
    logic             any_op, multi_op, wr_illegal, wr_ok, wr_denied;
    logic             rd_illegal, rd_grant, rd_denied;
    logic             tgt_owned, tgt_access, rd_access;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] rd_data_q,    rd_data_d;
    logic             rd_valid_q,   rd_valid_d;
    logic             fault_q,      fault_d;
    fault_code_t      fault_code_q, fault_code_d;

    assign wr_addr_ok = int'(wr_addr) < DEPTH;
    assign rd_addr_ok = int'(rd_addr) < DEPTH;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        protected_rf_entry #(
            .WIDTH (WIDTH),
            .ID_W  (ID_W)
        ) u_entry (
            .clk          (clk),
            .reset        (reset),
            .req_id_i     (req_id),
            .claim_i      (wr_sel[g] & claim),
            .release_i    (wr_sel[g] & release_i),
            .write_i      (wr_sel[g] & wr_en),
            .wr_data_i    (wr_data),
            .data_o       (ent_data[g]),
            .can_access_o (ent_access[g]),
            .is_owned_o   (ent_owned[g])
        );
    end

    // Address decode: pick out the write target and the read source entry.
    always_comb begin
        wr_sel     = '0;
        tgt_owned  = 1'b0;
        tgt_access = 1'b0;
        rd_access  = 1'b0;
        rd_word    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                wr_sel[i]  = wr_ok;
                tgt_owned  = ent_owned[i];
                tgt_access = ent_access[i];
            end
            if (rd_addr == ADDR_W'(i)) begin
                rd_access = ent_access[i];
                rd_word   = ent_data[i];
            end
        end
    end

    // Legality, permission and fault-priority evaluation; output next-state.
    always_comb begin
        any_op     = wr_en | claim | release_i;
        multi_op   = (wr_en & claim) | (wr_en & release_i) | (claim & release_i);
        wr_illegal = multi_op | (any_op & ~wr_addr_ok);
        wr_ok      = any_op & ~wr_illegal;
        // A self-claim is a silent no-op; every other op needs ownership.
        wr_denied  = wr_ok & (claim ? (tgt_owned & ~tgt_access) : ~tgt_access);

        rd_illegal = rd_en & ~rd_addr_ok;
        rd_grant   = rd_en & rd_addr_ok & rd_access;
        rd_denied  = rd_en & rd_addr_ok & ~rd_access;

        rd_valid_d = rd_grant;
        rd_data_d  = rd_data_q;
        if (rd_grant) begin
            rd_data_d = rd_word;
        end else if (rd_en) begin
            rd_data_d = '0;
        end

        fault_code_d = FC_NONE;
        if (wr_illegal || rd_illegal) begin
            fault_code_d = FC_ILLEGAL;
        end else if (wr_denied) begin
            fault_code_d = FC_WRITE_DENIED;
        end else if (rd_denied) begin
            fault_code_d = FC_READ_DENIED;
        end
        fault_d = (fault_code_d != FC_NONE);
    end

    // Registered read and fault outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

`ifdef RD_HIZ_EN
    assign rd_data = rd_valid_q ? rd_data_q : {WIDTH{1'bz}};
`else
    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_protected_register_file.sv
// Table-driven bench for protected_register_file (DEPTH=6 so that rd_addr=DEPTH
// is representable). Each vector carries one cycle of requests and the
// outputs expected on the following cycle; expectations queue up as the
// stimulus is driven and are popped once the DUT has registered its outputs.
module tb_protected_register_file;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 6;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [ID_W-1:0]   req_id;
    logic              wr_en, claim, rel;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [WIDTH-1:0]  wr_data, rd_data;
    logic              rd_en, rd_valid, fault;
    logic [1:0]        fault_code;

    always #5 clk = ~clk;

    protected_register_file #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_id     (req_id),
        .wr_en      (wr_en),
        .claim      (claim),
        .release_i  (rel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fault      (fault),
        .fault_code (fault_code)
    );

    typedef struct {
        logic       rst;
        logic [3:0] id;
        logic       wr, cl, rl;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       rd;
        logic [2:0] ra;
        logic       ev;
        logic [7:0] ed;
        logic       ef;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input logic [3:0] id, input logic wr, input logic cl,
                                input logic rl, input logic [2:0] wa, input logic [7:0] wd,
                                input logic rd, input logic [2:0] ra, input logic ev,
                                input logic [7:0] ed, input logic ef, input logic [1:0] ec);
        vec_t v;
        v.rst = 1'b0; v.id = id; v.wr = wr; v.cl = cl; v.rl = rl; v.wa = wa; v.wd = wd;
        v.rd = rd; v.ra = ra; v.ev = ev; v.ed = ed; v.ef = ef; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t       e;
        logic [7:0] exp_d;
        @(negedge clk);
        reset = v.rst; req_id = v.id; wr_en = v.wr; claim = v.cl; rel = v.rl;
        wr_addr = v.wa; wr_data = v.wd; rd_en = v.rd; rd_addr = v.ra;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        exp_d = e.ed;
`ifdef RD_HIZ_EN
        if (!e.ev) exp_d = 'z;
`endif
        check({tag, " rd_valid"},   {7'd0, rd_valid}, {7'd0, e.ev});
        check({tag, " rd_data"},    rd_data,          exp_d);
        check({tag, " fault"},      {7'd0, fault},    {7'd0, e.ef});
        check({tag, " fault_code"}, {6'd0, fault_code}, {6'd0, e.ec});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t r;
        reset = 1'b1; req_id = '0; wr_en = 0; claim = 0; rel = 0;
        wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;

        // Reset state, with a request present that reset must override.
        r = mk(4'd3, 0, 1, 0, 3'd2, 8'h00, 1, 3'd2, 0, 8'h00, 0, 2'd0);
        r.rst = 1'b1;
        apply(r, "reset0");
        apply(r, "reset1");

        vecs.push_back(mk(4'd3, 0, 1, 0, 3'd2, 8'h00, 0, 3'd0, 0, 8'h00, 0, 2'd0)); // claim
        vecs.push_back(mk(4'd3, 1, 0, 0, 3'd2, 8'hA5, 0, 3'd0, 0, 8'h00, 0, 2'd0)); // write
        vecs.push_back(mk(4'd3, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 8'hA5, 0, 2'd0)); // owner read
        vecs.push_back(mk(4'd5, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 8'h00, 1, 2'd1)); // foreign read
        vecs.push_back(mk(4'd5, 1, 0, 0, 3'd2, 8'h5A, 0, 3'd0, 0, 8'h00, 1, 2'd2)); // foreign write
        vecs.push_back(mk(4'd3, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 8'hA5, 0, 2'd0)); // data intact
        vecs.push_back(mk(4'd3, 0, 0, 1, 3'd2, 8'h00, 0, 3'd0, 0, 8'hA5, 0, 2'd0)); // release, hold
        vecs.push_back(mk(4'd3, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 8'h00, 1, 2'd1)); // read released
        vecs.push_back(mk(4'd5, 0, 1, 0, 3'd2, 8'h00, 0, 3'd0, 0, 8'h00, 0, 2'd0)); // id5 claims
        vecs.push_back(mk(4'd5, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 8'h00, 0, 2'd0)); // scrubbed
        vecs.push_back(mk(4'd5, 1, 1, 0, 3'd2, 8'hFF, 0, 3'd0, 0, 8'h00, 1, 2'd3)); // claim+write
        vecs.push_back(mk(4'd5, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 8'h00, 0, 2'd0)); // no change
        vecs.push_back(mk(4'd5, 0, 0, 0, 3'd0, 8'h00, 1, 3'd6, 0, 8'h00, 1, 2'd3)); // rd_addr=DEPTH
        vecs.push_back(mk(4'd5, 1, 0, 0, 3'd6, 8'hEE, 0, 3'd0, 0, 8'h00, 1, 2'd3)); // wr_addr=DEPTH
        vecs.push_back(mk(4'd5, 1, 0, 1, 3'd2, 8'hCC, 1, 3'd1, 0, 8'h00, 1, 2'd3)); // illegal > read
        vecs.push_back(mk(4'd5, 1, 0, 0, 3'd1, 8'hCC, 1, 3'd1, 0, 8'h00, 1, 2'd2)); // write > read
        vecs.push_back(mk(4'd5, 0, 1, 0, 3'd2, 8'h00, 0, 3'd0, 0, 8'h00, 0, 2'd0)); // self-claim
        vecs.push_back(mk(4'd7, 0, 1, 0, 3'd2, 8'h00, 0, 3'd0, 0, 8'h00, 1, 2'd2)); // foreign claim
        vecs.push_back(mk(4'd7, 0, 0, 1, 3'd2, 8'h00, 0, 3'd0, 0, 8'h00, 1, 2'd2)); // foreign release
        vecs.push_back(mk(4'd5, 1, 0, 0, 3'd2, 8'h11, 0, 3'd0, 0, 8'h00, 0, 2'd0)); // write 11
        vecs.push_back(mk(4'd5, 1, 0, 0, 3'd2, 8'h22, 1, 3'd2, 1, 8'h11, 0, 2'd0)); // rd-before-wr
        vecs.push_back(mk(4'd5, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 8'h22, 0, 2'd0)); // sees 22
        vecs.push_back(mk(4'd4, 0, 1, 0, 3'd0, 8'h00, 1, 3'd0, 0, 8'h00, 1, 2'd1)); // claim+read
        vecs.push_back(mk(4'd4, 0, 0, 0, 3'd0, 8'h00, 1, 3'd0, 1, 8'h00, 0, 2'd0)); // now granted
        vecs.push_back(mk(4'd4, 1, 0, 0, 3'd0, 8'h3C, 0, 3'd0, 0, 8'h00, 0, 2'd0)); // write 3C
        vecs.push_back(mk(4'd4, 0, 0, 0, 3'd0, 8'h00, 1, 3'd0, 1, 8'h3C, 0, 2'd0)); // read 3C
        vecs.push_back(mk(4'd9, 0, 1, 0, 3'd5, 8'h00, 0, 3'd0, 0, 8'h3C, 0, 2'd0)); // last entry
        vecs.push_back(mk(4'd9, 1, 0, 0, 3'd5, 8'h77, 0, 3'd0, 0, 8'h3C, 0, 2'd0));
        vecs.push_back(mk(4'd9, 0, 0, 0, 3'd0, 8'h00, 1, 3'd5, 1, 8'h77, 0, 2'd0));
        vecs.push_back(mk(4'd9, 0, 0, 1, 3'd3, 8'h00, 0, 3'd0, 0, 8'h77, 1, 2'd2)); // release unowned

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-sequence overrides a pending read and write.
        r = mk(4'd4, 1, 0, 0, 3'd0, 8'hFF, 1, 3'd0, 0, 8'h00, 0, 2'd0);
        r.rst = 1'b1;
        apply(r, "midreset");

        // Every previously owned entry is now unowned: owner reads are denied.
        apply(mk(4'd4, 0, 0, 0, 3'd0, 8'h00, 1, 3'd0, 0, 8'h00, 1, 2'd1), "post_rst_a0");
        apply(mk(4'd5, 0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 8'h00, 1, 2'd1), "post_rst_a2");
        apply(mk(4'd9, 0, 0, 0, 3'd0, 8'h00, 1, 3'd5, 0, 8'h00, 1, 2'd1), "post_rst_a5");
        // A fresh claim then read still works after reset, and the data was cleared.
        apply(mk(4'd9, 0, 1, 0, 3'd5, 8'h00, 0, 3'd0, 0, 8'h00, 0, 2'd0), "reclaim_a5");
        apply(mk(4'd9, 0, 0, 0, 3'd0, 8'h00, 1, 3'd5, 1, 8'h00, 0, 2'd0), "reread_a5");

        @(negedge clk);
        wr_en = 0; claim = 0; rel = 0; rd_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/protected_register_file.md
Name: protected_register_file

Overview:
- Parametrised successor to the single read/write-enabled register: a DEPTH x WIDTH register file where each entry carries an owner ID.
- Writes and reads are honoured only for the entry's owner. Entries are acquired with claim and returned with release; release scrubs the data.
- Sits between requesters (identified by req_id) and protected object storage; denied accesses raise a registered fault code instead of leaking data.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 8, number of entries (need not be a power of 2).
- ID_W, 4, requester/owner ID width.
- ADDR_W, $clog2(DEPTH) (minimum 1), address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_id  input  ID_W  requester ID for all operations this cycle.
- wr_en  input  1  write wr_data to wr_addr.
- claim  input  1  acquire entry wr_addr for req_id.
- release  input  1  relinquish entry wr_addr.
- wr_addr  input  ADDR_W  target of write/claim/release.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  WIDTH  read data, registered.
- rd_valid  output  1  one-cycle pulse, read granted.
- fault  output  1  one-cycle pulse, some access denied.
- fault_code  output  2  0 none, 1 READ_DENIED, 2 WRITE_DENIED, 3 ILLEGAL.

Behaviour:
- Per entry state: data[WIDTH], owner[ID_W], owned bit.
- Reset (sync, while reset=1): all data=0, owner=0, owned=0; rd_data=0, rd_valid=0, fault=0, fault_code=0. Reset overrides every request in the same cycle.
- Latency: all state updates take effect at the clock edge. rd_data, rd_valid and fault are registered and appear the cycle after the request.
- Write port, one operation per cycle. More than one of {wr_en, claim, release} asserted, or wr_addr >= DEPTH with any of them asserted -> ILLEGAL, no state change.
- claim:
  - Unowned entry -> owned=1, owner=req_id.
  - Owned by req_id -> no-op, no fault.
  - Owned by another ID -> WRITE_DENIED.
- release: owned by req_id -> owned=0, owner=0, data=0 (scrub). Otherwise -> WRITE_DENIED.
- wr_en: owned by req_id -> data=wr_data. Unowned or foreign owner -> WRITE_DENIED, data unchanged.
- rd_en:
  - Granted only if owned and owner==req_id: next cycle rd_data=data (value before any same-cycle write, i.e. read-before-write), rd_valid=1.
  - Denied: rd_data=0, rd_valid=0, READ_DENIED.
  - rd_addr >= DEPTH -> ILLEGAL.
- rd_data holds its last value when no read is granted (default build).
- Same-cycle read and write faults: one code reported, priority ILLEGAL > WRITE_DENIED > READ_DENIED; fault=1.
- Same-cycle claim and read of the same unowned entry: read is denied (checks use pre-edge ownership).
- Release followed by a read of that entry in the next cycle: READ_DENIED.

Optional Feature:
- Macro RD_HIZ_EN.
- Defined: rd_data is driven to all-Z (WIDTH bits) in every cycle where rd_valid=0, including during and after reset. Used for shared-bus integration, as in the earlier register.
- Undefined: rd_data is never Z; it holds the last granted value, or 0 after reset or a denied read.

Decomposition:
- Package protected_rf_pkg: fault code constants (FC_NONE=0, FC_READ_DENIED=1, FC_WRITE_DENIED=2, FC_ILLEGAL=3) and a 2-bit fault_code_t typedef.
- Sub-module protected_rf_entry, one instance per entry:
  - Holds data/owner/owned and the update logic.
  - Outputs can_access (owned && owner==req_id) and is_owned.
- Top level handles address decode, op legality, fault priority and the output registers.

Test Plan:
- Reset, then id=3 claims addr 2, writes 8'hA5; id=3 reads addr 2 -> next cycle rd_valid=1, rd_data=8'hA5, fault=0.
- id=5 reads addr 2 (owned by 3) -> rd_valid=0, rd_data=0, fault=1, fault_code=1. id=5 writes addr 2 -> fault_code=2, data still 8'hA5.
- id=3 releases addr 2, then reads it -> fault_code=1. id=5 claims addr 2 and reads it -> rd_data=0 (scrub verified).
- claim+wr_en in the same cycle, and rd_addr=DEPTH with DEPTH=6 -> fault_code=3, no state change. Illegal write op plus denied read -> code 3 reported.
- Owner writes 8'h11 then 8'h22 to the same addr while reading it in the second write's cycle -> rd_data=8'h11 (read-before-write). Reset asserted mid-sequence -> all outputs 0 and every entry unowned.
- With RD_HIZ_EN defined: rd_data==all-Z whenever rd_valid=0, and a valid value only in granted cycles.
